// File: rtl/i2c_tx.sv
// I2C master byte transmitter: START, 8 data bits MSB-first, ACK slot, STOP.
// Open-drain enables only; pads and tri-states live at the top level.
module i2c_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       ack_ok,
  output logic       nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    ACK,
    HOLD,
    STOP
  } state_t;

  state_t      state;
  state_t      n_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] n_cnt;
  logic [1:0]  qtr;
  logic [1:0]  n_qtr;
  logic [2:0]  idx;
  logic [2:0]  n_idx;
  logic [7:0]  shreg;
  logic [7:0]  n_shreg;
  logic        last_r;
  logic        n_last;
  logic        samp;
  logic        n_samp;
  logic        n_ack;
  logic        n_nack;
  logic        n_scl;
  logic        n_sda;
  logic        qend;
  logic        hs;

  assign qend = (cnt == CMAX);
  assign hs   = tx_valid && tx_ready;

  // Next-state, quarter timer, bit index and capture registers
  always_comb begin
    n_state = state;
    n_cnt   = qend ? '0 : cnt + CW'(1);
    n_qtr   = qend ? qtr + 2'd1 : qtr;
    n_idx   = idx;
    n_shreg = shreg;
    n_last  = last_r;
    n_samp  = samp;
    n_ack   = 1'b0;
    n_nack  = 1'b0;
    case (state)
      IDLE: begin
        n_cnt = '0;
        n_qtr = 2'd0;
        if (hs) begin
          n_state = START;
          n_shreg = tx_data;
          n_last  = tx_last;
        end
      end
      START: begin
        if (qend && qtr == 2'd1) begin
          n_state = BIT;
          n_qtr   = 2'd0;
          n_idx   = 3'd7;
        end
      end
      BIT: begin
        if (qend && qtr == 2'd3) begin
          if (idx == 3'd0) n_state = ACK;
          else n_idx = idx - 3'd1;
        end
      end
      ACK: begin
        if (qend && qtr == 2'd2) n_samp = sda_in;
        if (qend && qtr == 2'd3) begin
          if (!samp) begin
            n_ack   = 1'b1;
            n_state = last_r ? STOP : HOLD;
          end else begin
            n_nack  = 1'b1;
            n_state = STOP;
          end
        end
      end
      HOLD: begin
        n_cnt = '0;
        n_qtr = 2'd0;
        if (hs) begin
          n_state = BIT;
          n_idx   = 3'd7;
          n_shreg = tx_data;
          n_last  = tx_last;
        end
      end
      STOP: begin
        if (qend && qtr == 2'd3) n_state = IDLE;
      end
      default: n_state = IDLE;
    endcase
  end

  // Line enables decoded from the upcoming state so they can be registered
  always_comb begin
    n_scl = 1'b0;
    n_sda = 1'b0;
    case (n_state)
      START: n_sda = (n_qtr == 2'd1);
      BIT: begin
        n_scl = ~n_qtr[1];
        n_sda = ~n_shreg[n_idx];
      end
      ACK:  n_scl = ~n_qtr[1];
      HOLD: n_scl = 1'b1;
      STOP: begin
        n_scl = ~n_qtr[1];
        n_sda = (n_qtr != 2'd3);
      end
      default: begin
        n_scl = 1'b0;
        n_sda = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset releases the bus without a STOP
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      qtr      <= 2'd0;
      idx      <= 3'd0;
      shreg    <= 8'd0;
      last_r   <= 1'b0;
      samp     <= 1'b0;
      ack_ok   <= 1'b0;
      nack     <= 1'b0;
      busy     <= 1'b0;
      tx_ready <= 1'b1;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
    end else begin
      state    <= n_state;
      cnt      <= n_cnt;
      qtr      <= n_qtr;
      idx      <= n_idx;
      shreg    <= n_shreg;
      last_r   <= n_last;
      samp     <= n_samp;
      ack_ok   <= n_ack;
      nack     <= n_nack;
      busy     <= (n_state != IDLE);
      tx_ready <= (n_state == IDLE) || (n_state == HOLD);
      scl_oe   <= n_scl;
      sda_oe   <= n_sda;
    end
  end

endmodule

// File: tb/tb_i2c_tx.sv
// Bench for i2c_tx: bus-level monitor decodes START/bits/STOP,
// scoreboard queues hold expected bytes and slave responses.
module tb_i2c_tx;

  logic       clk;
  logic       rstn;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       ack_ok;
  logic       nack;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;
  logic       slave_pull;
  logic       slave_nack;

  int pass_cnt;
  int total_cnt;
  int nstart;
  int nstop;
  int bitcnt;

  logic [7:0] exp_bytes[$];
  logic       exp_resp[$];

  assign sda_in = ~(sda_oe | slave_pull);

  i2c_tx #(.CLK_DIV(4)) dut (
    .clk(clk),
    .rstn(rstn),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .ack_ok(ack_ok),
    .nack(nack),
    .busy(busy),
    .scl_oe(scl_oe),
    .sda_oe(sda_oe),
    .sda_in(sda_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s", name);
  endtask

  // Bus monitor: decodes line events and pops the scoreboard
  initial begin
    logic scl, sda, pscl, psda;
    logic [7:0] shv;
    logic [7:0] eb;
    logic er;
    pscl = 1'b1;
    psda = 1'b1;
    shv = 8'd0;
    forever begin
      @(negedge clk);
      scl = ~scl_oe;
      sda = sda_in;
      if (!rstn) begin
        bitcnt = 0;
        slave_pull = 1'b0;
      end else begin
        if (scl && pscl && psda && !sda) begin
          nstart++;
          bitcnt = 0;
        end else if (scl && pscl && !psda && sda) begin
          nstop++;
        end
        if (scl && !pscl) begin
          if (bitcnt < 8) shv = {shv[6:0], sda};
          bitcnt++;
          if (bitcnt == 8) begin
            if (exp_bytes.size() == 0) fail_now("unexpected_byte");
            else begin
              eb = exp_bytes.pop_front();
              chk("bus_byte", {24'd0, shv}, {24'd0, eb});
            end
          end else if (bitcnt == 9) begin
            bitcnt = 0;
          end
        end
        if (!scl && pscl) slave_pull = (bitcnt == 8) && !slave_nack;
        if (ack_ok && nack) fail_now("ack_and_nack_both_high");
        else if (ack_ok || nack) begin
          if (exp_resp.size() == 0) fail_now("unexpected_pulse");
          else begin
            er = exp_resp.pop_front();
            chk("slave_resp", {31'd0, nack}, {31'd0, er});
          end
        end
      end
      pscl = scl;
      psda = sda;
    end
  end

  // Issue one byte; expectations are pushed at handshake time
  task automatic send(input logic [7:0] d, input logic l, input logic nk,
                      input logic scramble);
    int t;
    t = 0;
    while (!tx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) fail_now("send_timeout");
    slave_nack = nk;
    tx_valid = 1'b1;
    tx_data = d;
    tx_last = l;
    exp_bytes.push_back(d);
    exp_resp.push_back(nk);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last = 1'b0;
    tx_data = scramble ? 8'h00 : 8'($urandom);
  endtask

  task automatic wait_idle(output int ncyc, output int nready);
    ncyc = 0;
    nready = 0;
    while (busy && ncyc < 5000) begin
      ncyc++;
      if (tx_ready) nready++;
      @(negedge clk);
    end
    if (busy) fail_now("idle_timeout");
  endtask

  task automatic wait_hold();
    int t;
    t = 0;
    while (!(busy && tx_ready) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!(busy && tx_ready)) fail_now("hold_timeout");
  endtask

  initial begin
    int nc, nr, hold_ok, t;
    logic [7:0] d;
    logic l, nk;
    pass_cnt = 0;
    total_cnt = 0;
    nstart = 0;
    nstop = 0;
    bitcnt = 0;
    slave_pull = 1'b0;
    slave_nack = 1'b0;
    rstn = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    tx_last = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", {26'd0, scl_oe, sda_oe, tx_ready, busy, ack_ok, nack},
          32'b001000);
    end
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_outs", {26'd0, scl_oe, sda_oe, tx_ready, busy, ack_ok, nack},
          32'b001000);
    end

    nstart = 0;
    nstop = 0;
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    wait_idle(nc, nr);
    chk("a5_busy_len", nc, 168);
    chk("a5_starts", nstart, 1);
    chk("a5_stops", nstop, 1);

    nstart = 0;
    nstop = 0;
    send(8'h3C, 1'b0, 1'b1, 1'b0);
    wait_idle(nc, nr);
    chk("nack_busy_len", nc, 168);
    chk("nack_ready_busy", nr, 0);
    chk("nack_stops", nstop, 1);

    nstart = 0;
    nstop = 0;
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    wait_hold();
    hold_ok = 0;
    repeat (50) begin
      if (scl_oe && !sda_oe && tx_ready && busy) hold_ok++;
      @(negedge clk);
    end
    chk("hold_scl_low", hold_ok, 50);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    wait_idle(nc, nr);
    chk("hold_starts", nstart, 1);
    chk("hold_stops", nstop, 1);

    nstart = 0;
    nstop = 0;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      l = (i == 7) ? 1'b1 : 1'($urandom_range(0, 1));
      nk = ($urandom_range(0, 3) == 0);
      send(d, l, nk, 1'b0);
      if (l || nk) begin
        wait_idle(nc, nr);
        chk("rand_busy_idle", {31'd0, busy}, 0);
      end else begin
        wait_hold();
      end
    end
    chk("rand_start_stop", nstart, nstop);

    send(8'h5A, 1'b1, 1'b0, 1'b0);
    t = 0;
    while (bitcnt != 3 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (bitcnt != 3) fail_now("bit4_timeout");
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {28'd0, scl_oe, sda_oe, busy, tx_ready}, 32'b0001);
    exp_bytes.delete();
    exp_resp.delete();
    rstn = 1'b1;
    @(negedge clk);
    nstart = 0;
    nstop = 0;
    send(8'hC3, 1'b1, 1'b0, 1'b0);
    wait_idle(nc, nr);
    chk("midrst_start", nstart, 1);
    chk("midrst_len", nc, 168);

    send(8'h81, 1'b1, 1'b0, 1'b1);
    wait_idle(nc, nr);

    repeat (4) @(negedge clk);
    chk("bytes_drained", exp_bytes.size(), 0);
    chk("resp_drained", exp_resp.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_tx.md
Name: i2c_tx

Overview:
- I2C master byte transmitter, the send-side counterpart of the existing byte receiver.
- Accepts bytes over a valid/ready handshake, generates START, shifts 8 bits MSB-first on SDA, samples the slave ACK, and generates STOP after the last byte or on NACK.
- Drives SCL and SDA as open-drain enables; pad and tri-state logic live at the top level.
- Single master only; no arbitration or clock-stretch detection.

Parameters:
- CLK_DIV, 4, clk cycles per SCL quarter-period; legal range ≥2; counter width $clog2(CLK_DIV).

Ports:
- clk  input  1  system clock
- rstn  input  1  synchronous active-low reset
- tx_valid  input  1  byte available
- tx_data  input  8  byte to send, MSB first
- tx_last  input  1  byte is last of transfer; qualified with tx_valid
- tx_ready  output  1  block can accept a byte this cycle
- ack_ok  output  1  one-cycle pulse: slave ACKed (SDA low in ACK slot)
- nack  output  1  one-cycle pulse: slave NACKed
- busy  output  1  high whenever state ≠ IDLE
- scl_oe  output  1  1 = pull SCL low, 0 = release
- sda_oe  output  1  1 = pull SDA low, 0 = release
- sda_in  input  1  sampled SDA line value

Behaviour:
- Reset: rstn is synchronous, active-low; clock is clk. While rstn=0 at a posedge:
  - state ← IDLE; all counters ← 0.
  - scl_oe=0, sda_oe=0, ack_ok=0, nack=0, busy=0, tx_ready=1.
- Mid-operation reset: bus is released on the next edge and no STOP is generated.
- Handshake:
  - A transfer occurs on a posedge with tx_valid && tx_ready.
  - tx_data and tx_last are captured into internal registers; later input changes are ignored.
  - tx_ready=1 only in IDLE and HOLD.
- Quarter timer:
  - Counts 0..CLK_DIV-1; each wrap ends one quarter.
  - Each bit slot is 4 quarters q0..q3:
    - q0–q1: scl_oe=1.
    - q2–q3: scl_oe=0.
  - SDA changes only at the start of q0, so it is stable while SCL is high.
- States:
  - IDLE: both lines released. On handshake → START.
  - START (2 quarters):
    - Quarter A: both released.
    - Quarter B: sda_oe=1, scl released.
    - Then → BIT with bit index 7.
  - BIT (8 slots):
    - sda_oe = ~shift_reg[idx] for the whole slot.
    - After q3 of idx 0 → ACK; otherwise idx-1.
  - ACK (1 slot):
    - sda_oe=0.
    - sda_in is sampled on the last clk of q2.
    - At end of q3:
      - sampled 0 → ack_ok pulse; then → STOP if the captured last=1, else → HOLD.
      - sampled 1 → nack pulse; → STOP regardless of last.
  - HOLD:
    - scl_oe=1, sda_oe=0, tx_ready=1; master holds SCL low indefinitely.
    - On handshake → BIT (no repeated START); the quarter timer restarts at q0.
  - STOP (4 quarters):
    - q0–q1: scl_oe=1, sda_oe=1.
    - q2: scl released, sda_oe=1.
    - q3: both released.
    - Then → IDLE.
- Latency and cycle counts:
  - Handshake to first START quarter: 1 clk.
  - START = 2·CLK_DIV clk.
  - Byte + ACK = 36·CLK_DIV clk.
  - STOP = 4·CLK_DIV clk.
- Pulse timing: ack_ok and nack pulse in the same cycle as the ACK→next-state transition and are never both high.
- busy=1 in START, BIT, ACK, HOLD and STOP.
- tx_valid outside IDLE/HOLD has no effect.

Test Plan:
- Reset held 3 clk mid-IDLE and after release -> scl_oe=0, sda_oe=0, tx_ready=1, busy=0, no pulses.
- CLK_DIV=4; send 0xA5 with tx_last=1; bench pulls SDA low in ACK slot ->
  - START then SDA bits 1,0,1,0,0,1,0,1 sampled at SCL high;
  - ack_ok one pulse, STOP;
  - busy high for exactly 8+144+16=168 clk.
- Send 0x3C with tx_last=0; slave NACKs -> nack one pulse, STOP follows immediately, HOLD never entered, tx_ready=0 until IDLE.
- Send 0x3C (last=0), ACK; wait 50 clk in HOLD; send 0xFF (last=1), ACK ->
  - SCL held low for all 50 clk with tx_ready=1;
  - only one START on the bus;
  - second byte bits all 1; STOP at end.
- Assert rstn=0 during bit index 4 of a byte -> next posedge scl_oe=0, sda_oe=0, busy=0; new handshake after reset starts with START.
- tx_data changed to 0x00 on the cycle after handshake of 0x81 -> bus shows 0x81.
